pe_mac: RTL and testbench
=========================

// Module: pe_mac
// PURPOSE
//  Signed multiply-accumulate processing element for the CNN datapath array.
//  Computes result = sat31(input1 * input2 + initsum) in two's complement.
//  Partial sums chain between PEs through the 31-bit initsum/result path.
//  Output is registered: one cycle of latency, one new operation every cycle.
// PARAMETERS
//  IN_W    16  width of each signed multiplicand
//  ACC_W   31  width of signed partial-sum input and result
// PORTS
//  clk      in   1      system clock, rising-edge active
//  rst_n    in   1      asynchronous active-low reset
//  input1   in   16     signed multiplicand A (activation)
//  input2   in   16     signed multiplicand B (weight)
//  initsum  in   31     signed incoming partial sum
//  result   out  31     signed saturated MAC result, registered
//  sat      out  1      high when the registered result was clamped
// BEHAVIOUR
//  - One clock, clk; reset is asynchronous and active-low (rst_n).
//  - Reset: result = 31'h0000_0000 and sat = 0, applied immediately on rst_n
//    falling. They hold until the first rising clk edge after rst_n rises.
//  - Reset mid-operation discards any in-flight value. There is no enable.
//  - Every rising edge registers the operands sampled at that edge:
//    result(t+1) = f(input1(t), input2(t), initsum(t)). Latency is 1 cycle.
//  - All operands are two's complement.
//  - prod = input1 * input2, full 32-bit signed product.
//    Range is -2^30+2^15 .. +2^30.
//  - sum = sign-extend(prod) + sign-extend(initsum), computed at 33 bits.
//    This sum cannot wrap internally.
//  - Saturation to the 31-bit signed range [-2^30, 2^30-1]:
//    - sum > 2^30-1: result = 31'h3FFF_FFFF, sat = 1.
//    - sum < -2^30: result = 31'h4000_0000, sat = 1.
//    - otherwise: result = sum[30:0], sat = 0.
//  - The product alone can overflow: 16'h8000*16'h8000 = +2^30 saturates
//    even when initsum = 0.
//  - Zero operand: result = initsum exactly (no clamp, since initsum is in range).
//  - The multiplier may be any combinational or DSP-inferred signed multiplier.
//    The adder and clamp logic must be explicit; no truncating assignment.
//  - No X propagation from reset: every output is driven from registers.
// TESTING
//  - Basic: input1=0002, input2=0008, initsum=0000_0005
//    -> result=0000_0015, sat=0.
//  - Signs: FFFF*FFFF + 0 -> 0000_0001.
//    FFFF*0001 + 0 -> 7FFF_FFFF (-1), sat=0.
//  - Product limits:
//    7FFF*7FFF + 0 -> 3FFF_0001, sat=0.
//    8000*8000 + 0 -> 3FFF_FFFF, sat=1.
//  - Sum clamp:
//    7FFF*8000 + 4000_0000 -> 4000_0000, sat=1 (negative clamp).
//    7FFF*7FFF + 3FFF_FFFF -> 3FFF_FFFF, sat=1 (positive clamp).
//  - Zero product: FFFC*0000 + 0000_0002 -> 0000_0002, sat=0.
//    Also check the 1-cycle latency against a back-to-back stream.
//  - Reset: assert rst_n low between clock edges mid-stream.
//    -> result=0, sat=0 immediately; first valid output one edge after release.

Source files
------------

// File: rtl/pe_mac.sv
// Signed multiply-accumulate processing element: result = sat(input1*input2 + initsum),
// registered with one cycle of latency and a flag marking clamped results.
module pe_mac #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  input1,
  input  logic [IN_W-1:0]  input2,
  input  logic [ACC_W-1:0] initsum,
  output logic [ACC_W-1:0] result,
  output logic             sat
);

  localparam int unsigned PROD_W = 2 * IN_W;
  // One guard bit above the wider addend so the sum can never wrap.
  localparam int unsigned SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  localparam logic [ACC_W-1:0] POS_SAT = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_SAT = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'($signed(POS_SAT));
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'($signed(NEG_SAT));

  logic signed [PROD_W-1:0] prod_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic [ACC_W-1:0]         result_c;
  logic                     sat_c;

  assign prod_c = $signed(input1) * $signed(input2);
  assign sum_c  = SUM_W'(prod_c) + SUM_W'($signed(initsum));

  // Clamp the exact sum into the signed ACC_W range.
  always_comb begin
    result_c = sum_c[ACC_W-1:0];
    sat_c    = 1'b0;
    if (sum_c > MAX_V) begin
      result_c = POS_SAT;
      sat_c    = 1'b1;
    end else if (sum_c < MIN_V) begin
      result_c = NEG_SAT;
      sat_c    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      sat    <= 1'b0;
    end else begin
      result <= result_c;
      sat    <= sat_c;
    end
  end

endmodule

// File: tb/tb_pe_mac.sv
// Self-checking bench for pe_mac: directed corner vectors, random back-to-back
// stream against an integer reference model, and a mid-stream asynchronous reset.
module tb_pe_mac;

  logic        clk;
  logic        rst_n;
  logic [15:0] input1;
  logic [15:0] input2;
  logic [30:0] initsum;
  logic [30:0] result;
  logic        sat;

  int tests = 0;
  int fails = 0;

  pe_mac dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .input1  (input1),
    .input2  (input2),
    .initsum (initsum),
    .result  (result),
    .sat     (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, then clamp to [-2^30, 2^30-1].
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [30:0] c,
                                output logic [30:0] r, output logic s);
    longint sum;
    sum = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
    if (sum > 64'sd1073741823) begin
      r = 31'h3FFF_FFFF;
      s = 1'b1;
    end else if (sum < -64'sd1073741824) begin
      r = 31'h4000_0000;
      s = 1'b1;
    end else begin
      r = 31'(sum);
      s = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [30:0] exp_r, input logic exp_s);
    tests++;
    assert (result === exp_r && sat === exp_s)
    else begin
      fails++;
      $error("FAIL %s: result=%h sat=%b expected result=%h sat=%b",
             tag, result, sat, exp_r, exp_s);
    end
  endtask

  // Drive operands between edges, clock once, sample 1 time unit after the edge.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [30:0] c);
    input1  = a;
    input2  = b;
    initsum = c;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [30:0] c, input logic [30:0] exp_r, input logic exp_s);
    logic [30:0] mr;
    logic        ms;
    apply(a, b, c);
    check(tag, exp_r, exp_s);
    model(a, b, c, mr, ms);
    check({tag, "_model"}, mr, ms);
  endtask

  task automatic random_op(input string tag);
    logic [15:0] a;
    logic [15:0] b;
    logic [30:0] c;
    logic [30:0] mr;
    logic        ms;
    a = 16'($urandom);
    b = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       c = 31'($urandom);
      1:       c = 31'h3FFF_0000 + 31'($urandom_range(0, 32'h1FFFF));
      2:       c = 31'h4000_0000 + 31'($urandom_range(0, 32'h1FFFF));
      default: c = 31'($urandom_range(0, 255));
    endcase
    if ($urandom_range(0, 7) == 0) a = 16'h8000;
    if ($urandom_range(0, 7) == 0) b = 16'h8000;
    apply(a, b, c);
    model(a, b, c, mr, ms);
    check(tag, mr, ms);
  endtask

  initial begin
    rst_n   = 1'b0;
    input1  = 16'h0;
    input2  = 16'h0;
    initsum = 31'h0;
    #1;
    check("reset_initial", 31'h0, 1'b0);
    input1  = 16'h1234;
    input2  = 16'h5678;
    initsum = 31'h0000_1111;
    @(posedge clk);
    #1;
    check("reset_held_over_edge", 31'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("basic",       16'h0002, 16'h0008, 31'h0000_0005, 31'h0000_0015, 1'b0);
    directed("neg_x_neg",   16'hFFFF, 16'hFFFF, 31'h0000_0000, 31'h0000_0001, 1'b0);
    directed("neg_x_pos",   16'hFFFF, 16'h0001, 31'h0000_0000, 31'h7FFF_FFFF, 1'b0);
    directed("max_prod",    16'h7FFF, 16'h7FFF, 31'h0000_0000, 31'h3FFF_0001, 1'b0);
    directed("min_x_min",   16'h8000, 16'h8000, 31'h0000_0000, 31'h3FFF_FFFF, 1'b1);
    directed("neg_clamp",   16'h7FFF, 16'h8000, 31'h4000_0000, 31'h4000_0000, 1'b1);
    directed("pos_clamp",   16'h7FFF, 16'h7FFF, 31'h3FFF_FFFF, 31'h3FFF_FFFF, 1'b1);
    directed("zero_prod",   16'hFFFC, 16'h0000, 31'h0000_0002, 31'h0000_0002, 1'b0);
    directed("zero_a_min",  16'h0000, 16'h1234, 31'h4000_0000, 31'h4000_0000, 1'b0);
    directed("edge_pos",    16'h0001, 16'h0001, 31'h3FFF_FFFE, 31'h3FFF_FFFF, 1'b0);
    directed("edge_pos_ov", 16'h0001, 16'h0002, 31'h3FFF_FFFE, 31'h3FFF_FFFF, 1'b1);
    directed("edge_neg_ov", 16'hFFFF, 16'h0001, 31'h4000_0000, 31'h4000_0000, 1'b1);

    // Back-to-back stream: a fresh operation lands on every edge.
    for (int i = 0; i < 200; i++) random_op("stream");

    // Mid-stream asynchronous reset between edges.
    input1  = 16'h7FFF;
    input2  = 16'h7FFF;
    initsum = 31'h0000_0100;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_immediate", 31'h0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_async_held", 31'h0, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", 31'h0, 1'b0);
    directed("first_after_reset", 16'h0003, 16'hFFFE, 31'h0000_0010, 31'h0000_000A, 1'b0);

    for (int i = 0; i < 50; i++) random_op("stream_post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
